// File: rtl/yarp_pkg.sv
// Shared types for the YARP decode stage: opcode enum, type-bit indices and the decoded entry.
package yarp_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'h03,
    OpImm    = 7'h13,
    OpAuipc  = 7'h17,
    OpStore  = 7'h23,
    OpReg    = 7'h33,
    OpLui    = 7'h37,
    OpBranch = 7'h63,
    OpJalr   = 7'h67,
    OpJal    = 7'h6F
  } riscv_op_e;

  // Bit positions inside the one-hot {j,u,b,s,i,r} type vector
  localparam int unsigned TypeR = 0;
  localparam int unsigned TypeI = 1;
  localparam int unsigned TypeS = 2;
  localparam int unsigned TypeB = 3;
  localparam int unsigned TypeU = 4;
  localparam int unsigned TypeJ = 5;

  localparam int unsigned XlenMax = 64;

  // pc/imm are held at the widest legal XLEN; narrower builds use the low bits
  typedef struct packed {
    logic [XlenMax-1:0] pc;
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XlenMax-1:0] imm;
    logic [5:0]         insn_type;
    logic               illegal;
  } decode_entry_t;

endpackage

// File: rtl/yarp_decode_core.sv
// Purely combinational RV32 instruction-to-decode_entry_t translator.
// Illegal-opcode flagging is built only with YARP_DECODE_ILLEGAL_EN defined.
module yarp_decode_core
  import yarp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decode_entry_t   entry_o
);

  logic w_sign;
  assign w_sign = instr_i[31];

  always_comb begin
    entry_o        = '0;
    entry_o.pc     = XlenMax'(pc_i);
    entry_o.op     = instr_i[6:0];
    entry_o.funct3 = instr_i[14:12];
    entry_o.funct7 = instr_i[31:25];
    entry_o.rs1    = instr_i[19:15];
    entry_o.rs2    = instr_i[24:20];
    entry_o.rd     = instr_i[11:7];

    case (instr_i[6:0])
      OpLoad, OpImm, OpJalr: begin
        entry_o.insn_type[TypeI] = 1'b1;
        entry_o.imm = {{52{w_sign}}, instr_i[31:20]};
      end
      OpStore: begin
        entry_o.insn_type[TypeS] = 1'b1;
        entry_o.imm = {{52{w_sign}}, instr_i[31:25], instr_i[11:7]};
      end
      OpBranch: begin
        entry_o.insn_type[TypeB] = 1'b1;
        entry_o.imm = {{51{w_sign}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OpJal: begin
        entry_o.insn_type[TypeJ] = 1'b1;
        entry_o.imm = {{43{w_sign}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                       1'b0};
      end
      OpLui, OpAuipc: begin
        entry_o.insn_type[TypeU] = 1'b1;
        entry_o.imm = {{32{w_sign}}, instr_i[31:12], 12'h000};
      end
      OpReg: begin
        entry_o.insn_type[TypeR] = 1'b1;
      end
      default: begin
        entry_o.insn_type = '0;
      end
    endcase

`ifdef YARP_DECODE_ILLEGAL_EN
    // Every recognised opcode ends in 2'b11, so "no type bit" covers both illegal cases
    entry_o.illegal = (entry_o.insn_type == '0);
`else
    entry_o.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/yarp_decode_stage.sv
// Decode stage: combinational decode in front of a DEPTH-entry FIFO of decoded entries.
// Define YARP_DECODE_ILLEGAL_EN to report unrecognised opcodes on illegal_o.
module yarp_decode_stage
  import yarp_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [4:0]                 rd_o,
  output logic [6:0]                 op_o,
  output logic [2:0]                 funct3_o,
  output logic [6:0]                 funct7_o,
  output logic [XLEN-1:0]            imm_o,
  output logic [5:0]                 type_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  decode_entry_t   w_entry;
  decode_entry_t   w_head;
  decode_entry_t   r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count, w_count_next;
  logic            w_push, w_pop;

  yarp_decode_core #(
    .XLEN (XLEN)
  ) u_core (
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .entry_o (w_entry)
  );

  // Explicit wrap so non-power-of-two depths never index past the last entry
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  assign in_ready_o  = (r_count < CntW'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CntW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_i && w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  assign w_head = out_valid_o ? r_mem[r_rd_ptr] : '0;

  assign pc_o      = w_head.pc[XLEN-1:0];
  assign rs1_o     = w_head.rs1;
  assign rs2_o     = w_head.rs2;
  assign rd_o      = w_head.rd;
  assign op_o      = w_head.op;
  assign funct3_o  = w_head.funct3;
  assign funct7_o  = w_head.funct7;
  assign imm_o     = w_head.imm[XLEN-1:0];
  assign type_o    = w_head.insn_type;
  assign illegal_o = w_head.illegal;
  assign count_o   = r_count;

  if (XLEN < XlenMax) begin : g_narrow
    logic w_unused_upper;
    assign w_unused_upper = ^{w_head.pc[XlenMax-1:XLEN], w_head.imm[XlenMax-1:XLEN]};
  end

endmodule

// File: tb/tb_yarp_decode_stage.sv
// Self-checking bench: two stages (DEPTH 2 and 3) on shared stimulus, each against a queue model.
module tb_yarp_decode_stage;

  localparam int XLEN = 32;
  localparam logic [63:0] Mask = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - XLEN);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  typ;
    logic        ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;

  logic            in_ready [2];
  logic            out_valid[2];
  logic [XLEN-1:0] pc_o     [2];
  logic [4:0]      rs1      [2];
  logic [4:0]      rs2      [2];
  logic [4:0]      rd       [2];
  logic [6:0]      op       [2];
  logic [2:0]      f3       [2];
  logic [6:0]      f7       [2];
  logic [XLEN-1:0] imm      [2];
  logic [5:0]      typ      [2];
  logic            ill      [2];
  logic [1:0]      count    [2];

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  yarp_decode_stage #(.XLEN(XLEN), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .pc_o(pc_o[0]), .rs1_o(rs1[0]), .rs2_o(rs2[0]), .rd_o(rd[0]), .op_o(op[0]),
    .funct3_o(f3[0]), .funct7_o(f7[0]), .imm_o(imm[0]), .type_o(typ[0]), .illegal_o(ill[0]),
    .count_o(count[0])
  );

  yarp_decode_stage #(.XLEN(XLEN), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .pc_o(pc_o[1]), .rs1_o(rs1[1]), .rs2_o(rs2[1]), .rd_o(rd[1]), .op_o(op[1]),
    .funct3_o(f3[1]), .funct7_o(f7[1]), .imm_o(imm[1]), .type_o(typ[1]), .illegal_o(ill[1]),
    .count_o(count[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Immediates built by shifting the sign-extended word rather than by bit concatenation
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] addr);
    exp_t   e;
    longint s;
    e     = '0;
    s     = longint'($signed(ins));
    e.pc  = addr & Mask;
    e.op  = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    case (int'(ins[6:0]))
      'h13, 'h03, 'h67: begin e.typ = 6'd2;  e.imm = 64'(s >>> 20); end
      'h23: begin
        e.typ = 6'd4;
        e.imm = 64'(s >>> 20) & ~64'h1f | 64'(ins[11:7]);
      end
      'h63: begin
        e.typ = 6'd8;
        e.imm = (64'(s >>> 19) & ~64'hfff) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
              | (64'(ins[11:8]) << 1);
      end
      'h6F: begin
        e.typ = 6'd32;
        e.imm = (64'(s >>> 11) & ~64'hfffff) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
              | (64'(ins[30:21]) << 1);
      end
      'h37, 'h17: begin e.typ = 6'd16; e.imm = 64'(s) & ~64'hfff; end
      'h33: e.typ = 6'd1;
      default: e.typ = 6'd0;
    endcase
    e.imm = e.imm & Mask;
`ifdef YARP_DECODE_ILLEGAL_EN
    e.ill = (e.typ == 6'd0);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_dut(input int i, input int depth, input int size, input exp_t h);
    string t;
    t = $sformatf("d%0d", depth);
    check_eq({t, ".out_valid"}, 64'(out_valid[i]), 64'(size != 0));
    check_eq({t, ".in_ready"},  64'(in_ready[i]),  64'(size < depth));
    check_eq({t, ".count"},     64'(count[i]),     64'(size));
    check_eq({t, ".pc"},        64'(pc_o[i]),      h.pc);
    check_eq({t, ".imm"},       64'(imm[i]),       h.imm);
    check_eq({t, ".fields"}, 64'({op[i], f3[i], f7[i], rs1[i], rs2[i], rd[i]}),
             64'({h.op, h.f3, h.f7, h.rs1, h.rs2, h.rd}));
    check_eq({t, ".type"},      64'(typ[i]),       64'(h.typ));
    check_eq({t, ".illegal"},   64'(ill[i]),       64'(h.ill));
  endtask

  // One clock: predict handshakes from pre-edge state, advance models, then check both DUTs
  task automatic step();
    bit   push0, pop0, push1, pop1;
    exp_t e;
    push0 = in_valid && (q0.size() < 2);
    pop0  = out_ready && (q0.size() != 0);
    push1 = in_valid && (q1.size() < 3);
    pop1  = out_ready && (q1.size() != 0);
    e     = ref_decode(instr, 64'(pc));
    @(posedge clk);
    if (reset || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back(e);
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back(e);
    end
    #1;
    check_dut(0, 2, q0.size(), (q0.size() != 0) ? q0[0] : exp_t'('0));
    check_dut(1, 3, q1.size(), (q1.size() != 0) ? q1[0] : exp_t'('0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 4) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    instr = 32'h00510093; pc = 'h40;
    step();
    step();
    check_eq("rst.in_ready", 64'(in_ready[0]), 64'd1);
    check_eq("rst.count", 64'(count[0]), 64'd0);

    // Fill with the consumer stalled
    reset = 1'b0; out_ready = 1'b0; instr = 32'h00510093; pc = 'h100;
    step();
    check_eq("addi.valid", 64'(out_valid[0]), 64'd1);
    check_eq("addi.type", 64'(typ[0]), 64'h02);
    check_eq("addi.rd", 64'(rd[0]), 64'd1);
    check_eq("addi.rs1", 64'(rs1[0]), 64'd2);
    check_eq("addi.imm", 64'(imm[0]), 64'd5);
    check_eq("addi.pc", 64'(pc_o[0]), 64'h100);
    instr = 32'hFE000EE3; pc = 'h104;
    step();
    check_eq("full.in_ready", 64'(in_ready[0]), 64'd0);
    check_eq("full.count", 64'(count[0]), 64'd2);
    instr = 32'h12345037; pc = 'h108;
    step();
    check_eq("drop.count", 64'(count[0]), 64'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_eq("beq.type", 64'(typ[0]), 64'h08);
    check_eq("beq.imm", 64'(imm[0]), 64'hFFFF_FFFC & Mask);
    step();
    check_eq("lui.type", 64'(typ[1]), 64'h10);
    check_eq("lui.imm", 64'(imm[1]), 64'h1234_5000);
    check_eq("drained.valid", 64'(out_valid[0]), 64'd0);
    step();

    // Flush while full, with a same-cycle push
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin instr = rand_instr(); pc = $urandom(); step(); end
    flush = 1'b1; instr = 32'h00000033;
    step();
    check_eq("flush.count", 64'(count[0]), 64'd0);
    check_eq("flush.valid", 64'(out_valid[0]), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();

    in_valid = 1'b1; instr = 32'h0000007F; pc = 'h200;
    step();
    check_eq("ill.type", 64'(typ[0]), 64'd0);
`ifdef YARP_DECODE_ILLEGAL_EN
    check_eq("ill.flag", 64'(ill[0]), 64'd1);
`else
    check_eq("ill.flag", 64'(ill[0]), 64'd0);
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Prefill two, then stream push+pop so DEPTH=3 pointers wrap repeatedly
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin instr = rand_instr(); pc = $urandom(); step(); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      instr = rand_instr(); pc = $urandom();
      step();
      check_eq("stream.count", 64'(count[1]), 64'd2);
    end

    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 79) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      instr     = rand_instr();
      pc        = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
